// File: rtl/sr_latch_writer_pkg.sv
// rtl/sr_latch_writer_pkg.sv - shared types, defaults and S/R drive helper for sr_latch_writer
// Contents:
//   sr_wr_state_t   write sequencer states
//   SR_DEF_*        default parameter values
//   sr_levels()     returns {S, R} for a data/mask pair, zero-extended to SR_MAX_WIDTH bits each
package sr_latch_writer_pkg;

    localparam int SR_DEF_WIDTH      = 4;
    localparam int SR_DEF_SETUP_CYC  = 1;
    localparam int SR_DEF_STROBE_CYC = 2;
    localparam int SR_DEF_HOLD_CYC   = 1;
    localparam int SR_MAX_WIDTH      = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_VERIFY,
        ST_DONE
    } sr_wr_state_t;

    // Masked-off bits get S=R=0 so the latch keeps its value; S and R can never both be 1.
    function automatic logic [2*SR_MAX_WIDTH-1:0] sr_levels(
        input logic [SR_MAX_WIDTH-1:0] data,
        input logic [SR_MAX_WIDTH-1:0] mask
    );
        return {mask & data, mask & ~data};
    endfunction

endpackage

// File: rtl/sr_latch_writer_phase_timer.sv
// rtl/sr_latch_writer_phase_timer.sv - loadable down-counter timing the SETUP/STROBE/HOLD phases
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         load load_value this cycle (phase entry)
//   load_value   phase length minus one
//   value        current count
//   zero         count has reached 0 (last cycle of the phase)
module sr_phase_timer #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_value,
    output logic [CW-1:0] value,
    output logic          zero
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (value != '0) begin
            value <= value - 1'b1;
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/sr_latch_writer.sv
// rtl/sr_latch_writer.sv - write sequencer turning masked words into S/R levels plus a latch gate strobe
// Optional feature macro: SR_LATCH_WRITER_VERIFY_EN (adds VERIFY state, q_in readback, err pulse).
// Ports:
//   clk1, rst_n        clock, asynchronous active-low reset
//   wr_valid/wr_ready  write request handshake; ready only in IDLE
//   wr_data, wr_mask   target values and per-bit write enable
//   S, R, en           per-bit set/reset levels and latch gate (all registered)
//   q_in               latch readback (used only with the verify feature)
//   done, err          one-cycle completion pulse and readback mismatch flag
module sr_latch_writer
    import sr_latch_writer_pkg::*;
#(
    parameter int WIDTH      = SR_DEF_WIDTH,
    parameter int SETUP_CYC  = SR_DEF_SETUP_CYC,
    parameter int STROBE_CYC = SR_DEF_STROBE_CYC,
    parameter int HOLD_CYC   = SR_DEF_HOLD_CYC
) (
    input  logic             clk1,
    input  logic             rst_n,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [WIDTH-1:0] wr_mask,
    output logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] R,
    output logic             en,
    input  logic [WIDTH-1:0] q_in,
    output logic             done,
    output logic             err
);

    localparam int MAX_AB  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int MAX_CYC = (MAX_AB > HOLD_CYC) ? MAX_AB : HOLD_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    sr_wr_state_t     state, state_nx;
    logic [WIDTH-1:0] data_q, mask_q, data_nx, mask_nx;
    logic             accept;
    logic             t_load, t_zero;
    logic [CW-1:0]    t_load_value;
    logic [CW-1:0]    unused_timer_value;
    logic [WIDTH-1:0] s_d, r_d;
    logic             en_d, done_d, err_d;
    logic             mismatch;

    assign wr_ready = (state == ST_IDLE);
    assign accept   = wr_valid & wr_ready;
    assign data_nx  = accept ? wr_data : data_q;
    assign mask_nx  = accept ? wr_mask : mask_q;

`ifdef SR_LATCH_WRITER_VERIFY_EN
    assign mismatch = |((q_in ^ data_q) & mask_q);
`else
    logic unused_q_in;
    assign unused_q_in = ^q_in;
    assign mismatch    = 1'b0;
`endif

    sr_phase_timer #(.CW(CW)) u_timer (
        .clk        (clk1),
        .rst_n      (rst_n),
        .load       (t_load),
        .load_value (t_load_value),
        .value      (unused_timer_value),
        .zero       (t_zero)
    );

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            mask_q <= '0;
        end else begin
            data_q <= data_nx;
            mask_q <= mask_nx;
        end
    end

    // The timer is reloaded on the edge that enters each timed phase.
    always_comb begin
        state_nx     = state;
        t_load       = 1'b0;
        t_load_value = '0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nx     = ST_SETUP;
                    t_load       = 1'b1;
                    t_load_value = CW'(SETUP_CYC - 1);
                end
            end
            ST_SETUP: begin
                if (t_zero) begin
                    state_nx     = ST_STROBE;
                    t_load       = 1'b1;
                    t_load_value = CW'(STROBE_CYC - 1);
                end
            end
            ST_STROBE: begin
                if (t_zero) begin
                    state_nx     = ST_HOLD;
                    t_load       = 1'b1;
                    t_load_value = CW'(HOLD_CYC - 1);
                end
            end
            ST_HOLD: begin
                if (t_zero) begin
`ifdef SR_LATCH_WRITER_VERIFY_EN
                    state_nx = ST_VERIFY;
`else
                    state_nx = ST_DONE;
`endif
                end
            end
`ifdef SR_LATCH_WRITER_VERIFY_EN
            ST_VERIFY: state_nx = ST_DONE;
`endif
            ST_DONE:   state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // Outputs are computed from the next state and registered, so S/R/en change
    // together with the state and never glitch from the request inputs.
    always_comb begin
        s_d    = '0;
        r_d    = '0;
        en_d   = 1'b0;
        done_d = 1'b0;
        err_d  = 1'b0;
        case (state_nx)
            ST_SETUP, ST_STROBE, ST_HOLD: begin
                s_d  = WIDTH'(sr_levels(SR_MAX_WIDTH'(data_nx), SR_MAX_WIDTH'(mask_nx)) >> SR_MAX_WIDTH);
                r_d  = WIDTH'(sr_levels(SR_MAX_WIDTH'(data_nx), SR_MAX_WIDTH'(mask_nx)));
                en_d = (state_nx == ST_STROBE);
            end
            ST_DONE: begin
                done_d = 1'b1;
                err_d  = (state == ST_VERIFY) & mismatch;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            S    <= '0;
            R    <= '0;
            en   <= 1'b0;
            done <= 1'b0;
            err  <= 1'b0;
        end else begin
            S    <= s_d;
            R    <= r_d;
            en   <= en_d;
            done <= done_d;
            err  <= err_d;
        end
    end

endmodule

// File: tb/tb_sr_latch_writer.sv
// tb/tb_sr_latch_writer.sv - randomized scoreboard bench for sr_latch_writer
`timescale 1ns/1ps
module tb_sr_latch_writer;

    localparam int W      = 4;
    localparam int SETUP  = 1;
    localparam int STROBE = 2;
    localparam int HOLD   = 1;
`ifdef SR_LATCH_WRITER_VERIFY_EN
    localparam int LAT = SETUP + STROBE + HOLD + 2;
    localparam bit VER = 1'b1;
`else
    localparam int LAT = SETUP + STROBE + HOLD + 1;
    localparam bit VER = 1'b0;
`endif

    logic         clk1 = 1'b0;
    logic         rst_n = 1'b0;
    logic         wr_valid = 1'b0;
    logic [W-1:0] wr_data = '0, wr_mask = '0, q_in = '0;
    logic         wr_ready, en, done, err;
    logic [W-1:0] S, R;

    typedef struct {
        logic [W-1:0] s;
        logic [W-1:0] r;
        logic         e;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0, next_free = 0;
    int   checks = 0, failures = 0;
    int   n_acc = 0, n_done = 0, n_abort = 0;
    logic prev_en = 1'b0;
    logic [W-1:0] prev_s = '0, prev_r = '0;
    logic finished = 1'b0;

    sr_latch_writer #(
        .WIDTH(W), .SETUP_CYC(SETUP), .STROBE_CYC(STROBE), .HOLD_CYC(HOLD)
    ) dut (
        .clk1(clk1), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .wr_mask(wr_mask), .S(S), .R(R), .en(en),
        .q_in(q_in), .done(done), .err(err)
    );

    always #5 clk1 = ~clk1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, req);
        end
    endtask

    // Reference model: a request is taken on any edge where valid is high and at
    // least LAT+1 cycles have passed since the previous acceptance.
    always @(posedge clk1) begin : push_blk
        exp_t it;
        cyc++;
        if (rst_n && wr_valid && cyc >= next_free) begin
            it.s   = wr_data & wr_mask;
            it.r   = ~wr_data & wr_mask;
            it.e   = VER && (((q_in ^ wr_data) & wr_mask) != '0);
            it.acc = cyc;
            sb.push_back(it);
            next_free = cyc + LAT + 1;
            n_acc++;
        end
    end

    always @(negedge clk1) begin : mon_blk
        int   off;
        exp_t it;
        if (!rst_n) begin
            prev_en = 1'b0;
        end else if (!finished) begin
            check("ready", wr_ready, cyc >= next_free - 1);
            check("s_and_r_overlap", S & R, 0);
            if (en && prev_en) begin
                check("s_stable_in_strobe", S, prev_s);
                check("r_stable_in_strobe", R, prev_r);
            end
            if (sb.size() != 0) begin
                it  = sb[0];
                off = cyc - it.acc;
                if (off < SETUP) begin
                    check("setup_s", S, it.s);
                    check("setup_r", R, it.r);
                    check("setup_en", en, 0);
                    check("setup_done", done, 0);
                end else if (off < SETUP + STROBE) begin
                    check("strobe_s", S, it.s);
                    check("strobe_r", R, it.r);
                    check("strobe_en", en, 1);
                    check("strobe_done", done, 0);
                end else if (off < SETUP + STROBE + HOLD) begin
                    check("hold_s", S, it.s);
                    check("hold_r", R, it.r);
                    check("hold_en", en, 0);
                    check("hold_done", done, 0);
                end else if (off < LAT - 1) begin
                    check("verify_sr", {S, R}, 0);
                    check("verify_en", en, 0);
                    check("verify_done", done, 0);
                end else begin
                    check("done_pulse", done, 1);
                    check("done_err", err, it.e);
                    check("done_sr", {S, R}, 0);
                    check("done_en", en, 0);
                    void'(sb.pop_front());
                    n_done++;
                end
            end else begin
                check("idle_sr", {S, R}, 0);
                check("idle_en", en, 0);
                check("idle_done", done, 0);
                check("idle_err", err, 0);
            end
            prev_en = en;
            prev_s  = S;
            prev_r  = R;
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk1);
        while (cyc < next_free - 1) begin
            n++;
            if (n > 50) begin
                failures++;
                $display("FAIL idle_timeout cycle=%0d got=busy expected=idle", cyc);
                return;
            end
            @(negedge clk1);
        end
    endtask

    task automatic do_write(input logic [W-1:0] d, input logic [W-1:0] m, input logic [W-1:0] q);
        wait_idle();
        wr_valid = 1'b1;
        wr_data  = d;
        wr_mask  = m;
        q_in     = q;
        @(negedge clk1);
        // Junk request while busy must be ignored.
        wr_valid = 1'($urandom_range(0, 1));
        wr_data  = W'($urandom);
        wr_mask  = W'($urandom);
    endtask

    initial begin
        int n;
        #3;
        check("rst_s", S, 0);
        check("rst_r", R, 0);
        check("rst_en", en, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_ready", wr_ready, 1);
        #10 rst_n = 1'b1;

        do_write(4'b1010, 4'b1111, 4'b1010);
        do_write(4'b1111, 4'b0011, 4'b1111);
        do_write(4'b0000, 4'b0000, 4'b0101);
        do_write(4'b0110, 4'b1111, 4'b0111);
        do_write(4'b0110, 4'b1111, 4'b0110);

        // Continuous valid with changing data.
        wait_idle();
        q_in = 4'b0011;
        for (int i = 0; i < 20; i++) begin
            wr_valid = 1'b1;
            wr_data  = W'($urandom);
            wr_mask  = W'($urandom);
            @(negedge clk1);
        end
        wr_valid = 1'b0;

        // Reset in the middle of the strobe.
        do_write(4'b1010, 4'b1111, 4'b1010);
        wr_valid = 1'b0;
        n = 0;
        while (!en && n < 10) begin
            @(negedge clk1);
            n++;
        end
        check("reach_strobe", en, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_en", en, 0);
        check("async_rst_s", S, 0);
        check("async_rst_r", R, 0);
        check("async_rst_done", done, 0);
        check("async_rst_ready", wr_ready, 1);
        sb.delete();
        next_free = 0;
        n_abort++;
        @(negedge clk1);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk1);
            do_write(W'($urandom), W'($urandom), W'($urandom));
        end

        wr_valid = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk1);
        check("scoreboard_empty", sb.size(), 0);
        check("done_count", n_done, n_acc - n_abort);
        finished = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
